// File: rtl/mem_access_unit_pkg.sv
// Shared MEM-stage definitions: FSM state encoding and bus width defaults.
package mem_access_unit_pkg;

   localparam int DATA_W_DEF = 16;
   localparam int ADDR_W_DEF = 16;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_BUSY = 2'd1,
      S_DONE = 2'd2
   } mau_state_t;

endpackage

// File: rtl/mem_access_unit_wait_timer.sv
// Counts BUSY cycles of a data-memory request and flags when the
// final allowed cycle is reached without a response.
module mem_wait_timer #(
   parameter int TIMEOUT = 64
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clr,
   input  logic en,
   output logic expired
);

   localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [CW-1:0] LAST = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

   logic [CW-1:0] cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
      end else if (clr) begin
         cnt <= '0;
      end else if (en) begin
         cnt <= cnt + 1'b1;
      end
   end

   // TIMEOUT of zero means wait forever
   assign expired = (TIMEOUT != 0) && en && (cnt == LAST);

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage data-memory controller: turns EX/MEM load/store control into
// a req/ready transaction, stalling upstream and bubbling mem_wb meanwhile.
module mem_access_unit
   import mem_access_unit_pkg::*;
#(
   parameter int DATA_W  = DATA_W_DEF,
   parameter int ADDR_W  = ADDR_W_DEF,
   parameter int TIMEOUT = 64
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              mem_read_m,
   input  logic              mem_write_m,
   input  logic              reg_write_m,
   input  logic [DATA_W-1:0] alu_result_m,
   input  logic [DATA_W-1:0] write_data_m,
   output logic              reg_write_out,
   output logic [DATA_W-1:0] mem_data_m,
   output logic              stall_m,
   output logic              dmem_req,
   output logic              dmem_we,
   output logic [ADDR_W-1:0] dmem_addr,
   output logic [DATA_W-1:0] dmem_wdata,
   input  logic [DATA_W-1:0] dmem_rdata,
   input  logic              dmem_ready,
   output logic              bus_err
);

   mau_state_t        state;
   mau_state_t        next_state;
   logic              access;
   logic              expired;
   logic              we_q;
   logic [ADDR_W-1:0] addr_q;
   logic [DATA_W-1:0] wdata_q;

   assign access = mem_read_m | mem_write_m;

   mem_wait_timer #(
      .TIMEOUT(TIMEOUT)
   ) u_timer (
      .clk    (clk),
      .rst_n  (rst_n),
      .clr    (state == S_IDLE),
      .en     (state == S_BUSY),
      .expired(expired)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= S_IDLE;
      end else begin
         state <= next_state;
      end
   end

   always_comb begin
      next_state = state;
      unique case (state)
         S_IDLE:  if (access) next_state = S_BUSY;
         S_BUSY:  if (dmem_ready || expired) next_state = S_DONE;
         S_DONE:  next_state = S_IDLE;
         default: next_state = S_IDLE;
      endcase
   end

   always_comb begin
      stall_m  = 1'b0;
      dmem_req = 1'b0;
      unique case (state)
         S_IDLE:  stall_m = access;
         S_BUSY: begin
            stall_m  = 1'b1;
            dmem_req = 1'b1;
         end
         default: ;
      endcase
   end

   // Ready beats a coincident timeout, so it is tested first
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         we_q       <= 1'b0;
         addr_q     <= '0;
         wdata_q    <= '0;
         mem_data_m <= '0;
         bus_err    <= 1'b0;
      end else begin
         if (state == S_IDLE && access) begin
            we_q    <= mem_write_m;
            addr_q  <= alu_result_m[ADDR_W-1:0];
            wdata_q <= write_data_m;
         end
         if (state == S_BUSY) begin
            if (dmem_ready) begin
               if (!we_q) mem_data_m <= dmem_rdata;
            end else if (expired) begin
               bus_err    <= 1'b1;
               mem_data_m <= '0;
            end
         end
      end
   end

   assign dmem_we       = we_q;
   assign dmem_addr     = addr_q;
   assign dmem_wdata    = wdata_q;
   assign reg_write_out = reg_write_m & ~stall_m;

endmodule

// File: tb/tb_mem_access_unit.sv
// Randomized scoreboard bench for mem_access_unit with a
// variable-latency memory responder and a per-instruction reference model.
module tb_mem_access_unit;

   localparam int TO = 4;

   logic        clk;
   logic        rst_n;
   logic        mem_read_m;
   logic        mem_write_m;
   logic        reg_write_m;
   logic [15:0] alu_result_m;
   logic [15:0] write_data_m;
   logic        reg_write_out;
   logic [15:0] mem_data_m;
   logic        stall_m;
   logic        dmem_req;
   logic        dmem_we;
   logic [15:0] dmem_addr;
   logic [15:0] dmem_wdata;
   logic [15:0] dmem_rdata;
   logic        dmem_ready;
   logic        bus_err;

   mem_access_unit #(
      .DATA_W (16),
      .ADDR_W (16),
      .TIMEOUT(TO)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .mem_read_m   (mem_read_m),
      .mem_write_m  (mem_write_m),
      .reg_write_m  (reg_write_m),
      .alu_result_m (alu_result_m),
      .write_data_m (write_data_m),
      .reg_write_out(reg_write_out),
      .mem_data_m   (mem_data_m),
      .stall_m      (stall_m),
      .dmem_req     (dmem_req),
      .dmem_we      (dmem_we),
      .dmem_addr    (dmem_addr),
      .dmem_wdata   (dmem_wdata),
      .dmem_rdata   (dmem_rdata),
      .dmem_ready   (dmem_ready),
      .bus_err      (bus_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        rw;
      logic [15:0] data;
      logic        err;
      int          stall;
      logic        mem;
      logic        we;
      logic [15:0] addr;
      logic [15:0] wdata;
   } exp_t;

   exp_t        sbq[$];
   int          dq[$];
   logic [15:0] ref_mem[256];
   logic [15:0] slv_mem[256];
   logic [15:0] last_data;
   logic        err_m;
   logic        tb_valid;
   int          checks;
   int          failures;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] want);
      checks++;
      if (act !== want) begin
         failures++;
         $display("FAIL %s got=%0h want=%0h at %0t", nm, act, want, $time);
      end
   endtask

   // Reference: one memory op = 1 detect cycle + busy cycles until
   // ready or timeout; timeout zeroes load data and sets sticky error.
   task automatic issue(input logic rd, input logic wr, input logic rw,
                        input logic [15:0] addr, input logic [15:0] wd,
                        input int d);
      exp_t e;
      int   n;
      e.mem   = rd | wr;
      e.we    = wr;
      e.addr  = addr;
      e.wdata = wd;
      e.rw    = rw;
      e.stall = 0;
      if (e.mem) begin
         if (d >= TO) begin
            last_data = '0;
            err_m     = 1'b1;
            e.stall   = 1 + TO;
         end else begin
            e.stall = d + 2;
            if (wr) ref_mem[addr[7:0]] = wd;
            else last_data = ref_mem[addr[7:0]];
         end
         dq.push_back(d);
      end
      e.data = last_data;
      e.err  = err_m;
      sbq.push_back(e);
      mem_read_m   = rd;
      mem_write_m  = wr;
      reg_write_m  = rw;
      alu_result_m = addr;
      write_data_m = wd;
      tb_valid     = 1'b1;
      n = 0;
      forever begin
         @(negedge clk);
         if (!stall_m) break;
         n++;
         if (n > 200) begin
            checks++;
            failures++;
            $display("FAIL retire_timeout instr still stalled after %0d cycles", n);
            break;
         end
      end
      @(posedge clk);
      #1;
      tb_valid    = 1'b0;
      mem_read_m  = 1'b0;
      mem_write_m = 1'b0;
      reg_write_m = 1'b0;
   endtask

   // Memory responder: ready after a per-transaction delay, spurious
   // ready pulses while no request is outstanding.
   initial begin
      bit active;
      int rd;
      int rc;
      active     = 0;
      rd         = 0;
      rc         = 0;
      dmem_ready = 1'b0;
      dmem_rdata = '0;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            active     = 0;
            dmem_ready = 1'b0;
         end else if (dmem_req) begin
            if (!active) begin
               active = 1;
               rd     = (dq.size() > 0) ? dq.pop_front() : 0;
               rc     = 0;
            end
            if (rc == rd) begin
               dmem_ready = 1'b1;
               if (dmem_we) begin
                  slv_mem[dmem_addr[7:0]] = dmem_wdata;
                  dmem_rdata = 16'($urandom);
               end else begin
                  dmem_rdata = slv_mem[dmem_addr[7:0]];
               end
            end else begin
               dmem_ready = 1'b0;
               dmem_rdata = 16'($urandom);
            end
            rc++;
         end else begin
            active     = 0;
            dmem_ready = ($urandom_range(0, 3) == 0);
            dmem_rdata = 16'($urandom);
         end
      end
   end

   // Monitor: bubbles and request stability while stalled, full
   // writeback comparison on the retiring cycle.
   initial begin
      int   scnt;
      exp_t e;
      scnt = 0;
      forever begin
         @(negedge clk);
         if (!rst_n || !tb_valid) begin
            scnt = 0;
         end else if (stall_m) begin
            scnt++;
            chk("bubble_rw", 32'(reg_write_out), 32'd0);
            if (dmem_req && sbq.size() > 0) begin
               chk("req_addr", 32'(dmem_addr), 32'(sbq[0].addr));
               chk("req_we", 32'(dmem_we), 32'(sbq[0].we));
               if (sbq[0].we) chk("req_wdata", 32'(dmem_wdata), 32'(sbq[0].wdata));
            end
         end else if (sbq.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL sb_underflow retire with got=empty want=entry");
         end else begin
            e = sbq.pop_front();
            chk("wb_rw", 32'(reg_write_out), 32'(e.rw));
            chk("mem_data", 32'(mem_data_m), 32'(e.data));
            chk("bus_err", 32'(bus_err), 32'(e.err));
            chk("stall_cycles", 32'(scnt), 32'(e.stall));
            chk("req_idle", 32'(dmem_req), 32'd0);
            scnt = 0;
         end
      end
   end

   initial begin
      int          n;
      logic [15:0] v;
      logic        rd;
      logic        wr;
      checks       = 0;
      failures     = 0;
      tb_valid     = 1'b0;
      last_data    = '0;
      err_m        = 1'b0;
      rst_n        = 1'b0;
      mem_read_m   = 1'b0;
      mem_write_m  = 1'b0;
      reg_write_m  = 1'b0;
      alu_result_m = '0;
      write_data_m = '0;
      for (int i = 0; i < 256; i++) begin
         v = 16'($urandom);
         ref_mem[i] = v;
         slv_mem[i] = v;
      end
      ref_mem[8'h40] = 16'hBEEF;
      slv_mem[8'h40] = 16'hBEEF;
      repeat (2) @(negedge clk);
      chk("rst_req", 32'(dmem_req), 32'd0);
      chk("rst_stall", 32'(stall_m), 32'd0);
      chk("rst_data", 32'(mem_data_m), 32'd0);
      chk("rst_err", 32'(bus_err), 32'd0);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      issue(1'b1, 1'b0, 1'b1, 16'h0040, 16'h0000, 0);

      // Reset while a request is outstanding
      dq.push_back(20);
      mem_read_m   = 1'b1;
      reg_write_m  = 1'b1;
      alu_result_m = 16'h0020;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!dmem_req && n < 10);
      chk("pre_rst_req", 32'(dmem_req), 32'd1);
      #2 rst_n = 1'b0;
      #1;
      chk("midrst_req", 32'(dmem_req), 32'd0);
      chk("midrst_data", 32'(mem_data_m), 32'd0);
      chk("midrst_err", 32'(bus_err), 32'd0);
      mem_read_m  = 1'b0;
      reg_write_m = 1'b0;
      #1;
      chk("midrst_idle", 32'(stall_m), 32'd0);
      @(negedge clk);
      rst_n     = 1'b1;
      last_data = '0;
      err_m     = 1'b0;
      @(posedge clk);
      #1;

      issue(1'b0, 1'b1, 1'b0, 16'h0012, 16'h1234, 3);
      issue(1'b1, 1'b0, 1'b1, 16'h0012, 16'h0000, TO - 1);
      issue(1'b1, 1'b1, 1'b1, 16'h0077, 16'h5555, 1);
      issue(1'b1, 1'b0, 1'b1, 16'h0100, 16'h0000, 0);
      issue(1'b1, 1'b0, 1'b1, 16'h0101, 16'h0000, 2);
      issue(1'b0, 1'b0, 1'b1, 16'h9999, 16'h0000, 0);
      issue(1'b0, 1'b0, 1'b0, 16'h1111, 16'h0000, 0);
      issue(1'b1, 1'b0, 1'b1, 16'h0040, 16'h0000, 10);

      for (int i = 0; i < 150; i++) begin
         rd = 1'($urandom_range(0, 1));
         wr = ($urandom_range(0, 2) == 0);
         issue(rd, wr, 1'($urandom_range(0, 1)), 16'($urandom),
               16'($urandom), $urandom_range(0, 5));
      end

      repeat (3) @(negedge clk);
      chk("sb_empty", 32'(sbq.size()), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
